// File: rtl/counter_bank_pkg.sv
// rtl/counter_bank_pkg.sv - shared state and mode encodings for the counter bank
package counter_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/counter_bank_if.sv
// rtl/counter_bank_if.sv - control, config and status bundle between datapath control and the counter bank
interface counter_bank_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8
);
  localparam int CHW = $clog2(NUM_CH);

  logic [NUM_CH-1:0]       countEN;
  logic [NUM_CH-1:0]       clear;
  logic                    cfg_we;
  logic [CHW-1:0]          cfg_ch;
  logic [WIDTH-1:0]        cfg_limit;
  logic                    cfg_mode;
  logic [NUM_CH*WIDTH-1:0] count;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH-1:0]       op_done;
  logic                    any_done;

  modport master (
    output countEN, clear, cfg_we, cfg_ch, cfg_limit, cfg_mode,
    input  count, busy, op_done, any_done
  );

  modport slave (
    input  countEN, clear, cfg_we, cfg_ch, cfg_limit, cfg_mode,
    output count, busy, op_done, any_done
  );
endinterface

// File: rtl/counter_bank_cnt_channel.sv
// rtl/counter_bank_cnt_channel.sv - one event-counter channel: FSM, count, limit and mode registers
module cnt_channel
  import counter_bank_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] DEF_LIMIT = WIDTH'(5)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_hit,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic             cfg_mode,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             op_done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;
  logic             terminal;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      limit_q <= DEF_LIMIT;
      mode_q  <= MODE_ONESHOT;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      limit_q <= limit_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  // Wraps modulo 2^WIDTH, so limit 0 terminates at all-ones after 2^WIDTH events.
  assign terminal = (count_q == limit_q - WIDTH'(1));

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    limit_d = limit_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    if (cfg_hit) begin
      limit_d = cfg_limit;
      mode_d  = cfg_mode;
      count_d = '0;
      state_d = ST_IDLE;
    end else if (clr) begin
      count_d = '0;
      state_d = ST_IDLE;
    end else if (en && state_q != ST_DONE) begin
      if (terminal) begin
        done_d = 1'b1;
        if (mode_q == MODE_RELOAD) begin
          count_d = '0;
          state_d = ST_COUNT;
        end else begin
          count_d = limit_q;
          state_d = ST_DONE;
        end
      end else begin
        count_d = count_q + WIDTH'(1);
        state_d = ST_COUNT;
      end
    end
  end

  always_comb begin
    count   = count_q;
    busy    = (state_q == ST_COUNT);
    op_done = done_q;
  end

endmodule

// File: rtl/counter_bank.sv
// rtl/counter_bank.sv - NUM_CH independent programmable event counters with per-channel completion pulses
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int WIDTH     = 8,
  parameter int DEF_LIMIT = 5
) (
  input  logic          clock,
  input  logic          reset,
  counter_bank_if.slave bus
);

  localparam int CHW = $clog2(NUM_CH);

  logic [NUM_CH*WIDTH-1:0] count_w;
  logic [NUM_CH-1:0]       busy_w;
  logic [NUM_CH-1:0]       done_w;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic hit;
    // cfg_ch values at or above NUM_CH never match any channel.
    assign hit = bus.cfg_we && (bus.cfg_ch == CHW'(i));

    cnt_channel #(
      .WIDTH     (WIDTH),
      .DEF_LIMIT (WIDTH'(DEF_LIMIT))
    ) u_ch (
      .clock     (clock),
      .reset     (reset),
      .cfg_hit   (hit),
      .cfg_limit (bus.cfg_limit),
      .cfg_mode  (bus.cfg_mode),
      .en        (bus.countEN[i]),
      .clr       (bus.clear[i]),
      .count     (count_w[i*WIDTH +: WIDTH]),
      .busy      (busy_w[i]),
      .op_done   (done_w[i])
    );
  end

  assign bus.count    = count_w;
  assign bus.busy     = busy_w;
  assign bus.op_done  = done_w;
  assign bus.any_done = |done_w;

endmodule

// File: tb/tb_counter_bank.sv
// tb/tb_counter_bank.sv - directed self-checking bench for counter_bank
module tb_counter_bank;
  localparam int NUM_CH = 4;
  localparam int WIDTH  = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  counter_bank_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) bus ();

  counter_bank #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DEF_LIMIT(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] cnt(input int ch);
    return bus.count[ch*WIDTH +: WIDTH];
  endfunction

  task automatic cfg(input int ch, input int lim, input logic mode);
    bus.cfg_we    = 1'b1;
    bus.cfg_ch    = 2'(ch);
    bus.cfg_limit = 8'(lim);
    bus.cfg_mode  = mode;
    tick();
    bus.cfg_we    = 1'b0;
  endtask

  int exp3[6] = '{1, 2, 0, 1, 2, 0};
  int pulses;

  initial begin
    bus.countEN = '0; bus.clear = '0; bus.cfg_we = 1'b0;
    bus.cfg_ch = '0; bus.cfg_limit = '0; bus.cfg_mode = 1'b0;

    // 1: reset and idle
    tick(); tick();
    reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus.op_done != 0 || bus.any_done) pulses++;
    end
    chk("idle_count", bus.count, 0);
    chk("idle_busy", bus.busy, 0);
    chk("idle_any_done", bus.any_done, 0);
    chk("idle_pulses", pulses, 0);
    bus.countEN[0] = 1'b1;
    tick(); tick();
    chk("pre_rst_count0", cnt(0), 2);
    chk("pre_rst_busy", bus.busy, 4'b0001);
    reset = 1'b1;
    #2;
    chk("async_rst_count", bus.count, 0);
    chk("async_rst_busy", bus.busy, 0);
    bus.countEN = '0;
    tick();
    reset = 1'b0;

    // 2: ch0 default one-shot limit 5
    bus.countEN[0] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("os_count_%0d", k), cnt(0), k);
      chk($sformatf("os_done_%0d", k), bus.op_done[0], (k == 5) ? 1 : 0);
      chk($sformatf("os_busy_%0d", k), bus.busy[0], (k == 5) ? 0 : 1);
    end
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.op_done[0]) pulses++;
      chk("os_hold_count", cnt(0), 5);
    end
    chk("os_hold_pulses", pulses, 0);
    bus.countEN[0] = 1'b0;
    bus.clear[0] = 1'b1;
    tick();
    bus.clear[0] = 1'b0;
    chk("os_cleared", cnt(0), 0);

    // 3: ch1 reload limit 3
    cfg(1, 3, 1'b1);
    bus.countEN[1] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("rl_count_%0d", k), cnt(1), exp3[k]);
      chk($sformatf("rl_done_%0d", k), bus.op_done[1], (k % 3 == 2) ? 1 : 0);
      chk($sformatf("rl_busy_%0d", k), bus.busy[1], 1);
    end
    bus.countEN[1] = 1'b0;

    // 4: ch2 with a two-cycle pause
    bus.countEN[2] = 1'b1;
    tick(); tick(); tick();
    chk("pause_pre", cnt(2), 3);
    bus.countEN[2] = 1'b0;
    tick();
    chk("pause_hold1", cnt(2), 3);
    tick();
    chk("pause_hold2", cnt(2), 3);
    chk("pause_busy", bus.busy[2], 1);
    chk("pause_no_done", bus.op_done[2], 0);
    bus.countEN[2] = 1'b1;
    tick();
    chk("pause_edge6", cnt(2), 4);
    chk("pause_done6", bus.op_done[2], 0);
    tick();
    chk("pause_edge7", cnt(2), 5);
    chk("pause_done7", bus.op_done[2], 1);
    bus.countEN[2] = 1'b0;

    // 5: clear beats countEN, config mid-count, simultaneous termination
    bus.countEN[0] = 1'b1;
    tick(); tick();
    chk("clr_pre", cnt(0), 2);
    bus.clear[0] = 1'b1;
    tick();
    bus.clear[0] = 1'b0;
    bus.countEN[0] = 1'b0;
    chk("clr_count", cnt(0), 0);
    chk("clr_busy", bus.busy[0], 0);
    bus.countEN[3] = 1'b1;
    tick(); tick();
    chk("cfg_pre", cnt(3), 2);
    bus.countEN[0] = 1'b1;
    cfg(3, 4, 1'b0);
    chk("cfg_mid_count3", cnt(3), 0);
    chk("cfg_mid_busy3", bus.busy[3], 0);
    chk("cfg_mid_count0", cnt(0), 1);
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus.any_done) pulses++;
    end
    chk("sim_early_any", pulses, 0);
    tick();
    chk("sim_count0", cnt(0), 5);
    chk("sim_count3", cnt(3), 4);
    chk("sim_op_done", bus.op_done, 4'b1001);
    chk("sim_any_done", bus.any_done, 1);
    tick();
    chk("sim_any_after", bus.any_done, 0);
    bus.countEN = '0;

    // 6: ch0 limit 0 means 256 events
    cfg(0, 0, 1'b0);
    bus.countEN[0] = 1'b1;
    pulses = 0;
    for (int k = 0; k < 255; k++) begin
      tick();
      if (bus.op_done[0]) pulses++;
    end
    chk("wrap_early_pulses", pulses, 0);
    chk("wrap_count255", cnt(0), 255);
    tick();
    chk("wrap_done", bus.op_done[0], 1);
    chk("wrap_count", cnt(0), 0);
    chk("wrap_busy", bus.busy[0], 0);
    tick();
    chk("wrap_hold_count", cnt(0), 0);
    chk("wrap_hold_done", bus.op_done[0], 0);
    bus.countEN = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
